// File: rtl/sched_pkg.sv
// sched_pkg: shared constants and types for the reservation-station issue
// scheduler (rs_issue_sched) and the logic that talks to it.
//   RS_ENTRIES / RS_IDX_W : default entry count and index width
//   entry_idx_t           : one RS entry index
//   entry_vec_t           : one bit per RS entry
//   OP_* constants        : opcodes shared with the RS operand storage
package sched_pkg;

  localparam int RS_ENTRIES = 4;
  localparam int RS_IDX_W   = $clog2(RS_ENTRIES);

  typedef logic [RS_IDX_W-1:0]   entry_idx_t;
  typedef logic [RS_ENTRIES-1:0] entry_vec_t;

  localparam logic [6:0] OP_REG = 7'b0110011;

endpackage

// File: rtl/rs_issue_sched_if.sv
// rs_issue_sched_if: groups the scheduler's allocate/ready/stall/flush inputs
// and its issue/status outputs.
//   slave  : the scheduler side (rs_issue_sched)
//   master : the surrounding ID / RS / EX / ROB side
interface rs_issue_sched_if
  import sched_pkg::*;
#(
  parameter int ENTRIES = RS_ENTRIES,
  parameter int IDX_W   = $clog2(ENTRIES)
);
  logic               alloc_valid_id2sched;
  logic [IDX_W-1:0]   alloc_idx_id2sched;
  logic [ENTRIES-1:0] ready_rs2sched;
  logic               stop_ex2sched;
  logic               flush_rob2sched;
  logic               issue_valid_sched2rs;
  logic [IDX_W-1:0]   issue_idx_sched2rs;
  logic [ENTRIES-1:0] free_sched2id;
  logic               full_sched2id;
  logic               alloc_err_sched2id;

  modport slave (
    input  alloc_valid_id2sched, alloc_idx_id2sched, ready_rs2sched,
           stop_ex2sched, flush_rob2sched,
    output issue_valid_sched2rs, issue_idx_sched2rs, free_sched2id,
           full_sched2id, alloc_err_sched2id
  );

  modport master (
    output alloc_valid_id2sched, alloc_idx_id2sched, ready_rs2sched,
           stop_ex2sched, flush_rob2sched,
    input  issue_valid_sched2rs, issue_idx_sched2rs, free_sched2id,
           full_sched2id, alloc_err_sched2id
  );
endinterface

// File: rtl/rs_age_matrix.sv
// rs_age_matrix: allocation-order matrix for the RS entries.
// older_q[i][j] = 1 means entry i was allocated before entry j.
//   clk, res      : clock, synchronous active-high reset
//   alloc_en      : entry alloc_idx is written this cycle (already legal)
//   alloc_idx     : entry being allocated
//   occ           : current occupancy, snapshot into the new entry's column
//   cand          : candidate vector to select from
//   oldest_onehot : the candidate no other candidate is older than (0 if none)
module rs_age_matrix
  import sched_pkg::*;
#(
  parameter int ENTRIES = RS_ENTRIES,
  parameter int IDX_W   = $clog2(ENTRIES)
) (
  input  logic               clk,
  input  logic               res,
  input  logic               alloc_en,
  input  logic [IDX_W-1:0]   alloc_idx,
  input  logic [ENTRIES-1:0] occ,
  input  logic [ENTRIES-1:0] cand,
  output logic [ENTRIES-1:0] oldest_onehot
);

  logic [ENTRIES-1:0] older_q [ENTRIES];
  logic [ENTRIES-1:0] older_d [ENTRIES];
  logic [ENTRIES-1:0] blocked;

  // The new entry is younger than everything currently occupied and older
  // than nothing. Rows of unoccupied entries may be stale; occ/cand mask them.
  always_comb begin
    older_d = older_q;
    if (alloc_en) begin
      for (int j = 0; j < ENTRIES; j++) begin
        if (IDX_W'(j) != alloc_idx) older_d[j][alloc_idx] = occ[j];
      end
      older_d[alloc_idx] = '0;
    end
  end

  // An entry is blocked when some other candidate is older than it.
  always_comb begin
    // NOTE: every always_comb output gets a default before any branch so no latch is inferred.
    blocked       = '0;
    oldest_onehot = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      for (int j = 0; j < ENTRIES; j++) begin
        blocked[i] = blocked[i] | (cand[j] & older_q[j][i]);
      end
      oldest_onehot[i] = cand[i] & ~blocked[i];
    end
  end

  // NOTE: the matrix is a small flop array, so it is reset like any other state rather than left as uninitialised storage.
  always_ff @(posedge clk) begin
    if (res) older_q <= '{default: '0};
    else     older_q <= older_d;
  end

endmodule

// File: rtl/rs_issue_sched.sv
// rs_issue_sched: reservation-station issue scheduler. Tracks entry
// occupancy and allocation age, and each cycle registers the oldest occupied
// entry whose operands are ready onto the issue outputs. A presented issue is
// held unchanged while EX asserts stop.
//   clk, res : clock, synchronous active-high reset
//   bus      : rs_issue_sched_if.slave (alloc, ready, stop, flush in;
//              issue, free, full, alloc_err out)
//   issued_cnt_sched, stall_cnt_sched : saturating fire / stall-cycle
//              counters, present only when RS_ISSUE_STATS_EN is defined
module rs_issue_sched
  import sched_pkg::*;
#(
  parameter int ENTRIES = RS_ENTRIES,
  parameter int IDX_W   = $clog2(ENTRIES)
) (
  input  logic         clk,
  input  logic         res,
  rs_issue_sched_if.slave bus
`ifdef RS_ISSUE_STATS_EN
  ,
  output logic [31:0]  issued_cnt_sched,
  output logic [31:0]  stall_cnt_sched
`endif
);

  localparam logic [ENTRIES-1:0] ONE = {{(ENTRIES-1){1'b0}}, 1'b1};

  logic [ENTRIES-1:0] occ_q, occ_d;
  logic               issue_valid_q, issue_valid_d;
  logic [IDX_W-1:0]   issue_idx_q, issue_idx_d;
  logic               alloc_err_q, alloc_err_d;

  logic               fire, stall, alloc_ok, alloc_bad;
  logic [ENTRIES-1:0] fire_mask, alloc_mask, cand, oldest_onehot;
  logic [IDX_W-1:0]   sel_idx;

  assign fire       = issue_valid_q & ~bus.stop_ex2sched;
  assign stall      = issue_valid_q & bus.stop_ex2sched;
  assign fire_mask  = fire ? (ONE << issue_idx_q) : '0;
  assign alloc_mask = ONE << bus.alloc_idx_id2sched;
  // An entry firing this cycle is still occupied, so allocating it is illegal.
  // Flush drops any same-cycle allocation, legal or not.
  assign alloc_bad  = bus.alloc_valid_id2sched & ~bus.flush_rob2sched
                    & |(occ_q & alloc_mask);
  assign alloc_ok   = bus.alloc_valid_id2sched & ~bus.flush_rob2sched
                    & ~|(occ_q & alloc_mask);
  // Dropping the firing entry lets the next oldest issue with no bubble.
  assign cand       = occ_q & bus.ready_rs2sched & ~fire_mask;

  rs_age_matrix #(.ENTRIES(ENTRIES), .IDX_W(IDX_W)) u_age (
    .clk          (clk),
    .res          (res),
    .alloc_en     (alloc_ok),
    .alloc_idx    (bus.alloc_idx_id2sched),
    .occ          (occ_q),
    .cand         (cand),
    .oldest_onehot(oldest_onehot)
  );

  always_comb begin
    sel_idx = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (oldest_onehot[i]) sel_idx = IDX_W'(i);
    end
  end

  always_comb begin
    occ_d         = (occ_q & ~fire_mask) | (alloc_ok ? alloc_mask : '0);
    issue_valid_d = |cand;
    issue_idx_d   = sel_idx;
    alloc_err_d   = alloc_err_q | alloc_bad;
    if (bus.flush_rob2sched) begin
      occ_d         = '0;
      issue_valid_d = 1'b0;
      issue_idx_d   = '0;
    end else if (stall) begin
      // No reordering under stall: even a newly ready older entry waits.
      issue_valid_d = issue_valid_q;
      issue_idx_d   = issue_idx_q;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
    if (res) begin
      occ_q         <= '0;
      issue_valid_q <= 1'b0;
      issue_idx_q   <= '0;
      alloc_err_q   <= 1'b0;
    end else begin
      occ_q         <= occ_d;
      issue_valid_q <= issue_valid_d;
      issue_idx_q   <= issue_idx_d;
      alloc_err_q   <= alloc_err_d;
    end
  end

  assign bus.issue_valid_sched2rs = issue_valid_q;
  assign bus.issue_idx_sched2rs   = issue_idx_q;
  assign bus.free_sched2id        = ~occ_q;
  assign bus.full_sched2id        = &occ_q;
  assign bus.alloc_err_sched2id   = alloc_err_q;

`ifdef RS_ISSUE_STATS_EN
  logic [31:0] issued_cnt_q, issued_cnt_d;
  logic [31:0] stall_cnt_q,  stall_cnt_d;

  // Saturating counters; only reset clears them, flush leaves them alone.
  always_comb begin
    issued_cnt_d = issued_cnt_q;
    stall_cnt_d  = stall_cnt_q;
    if (fire  && issued_cnt_q != '1) issued_cnt_d = issued_cnt_q + 32'd1;
    if (stall && stall_cnt_q  != '1) stall_cnt_d  = stall_cnt_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (res) begin
      issued_cnt_q <= '0;
      stall_cnt_q  <= '0;
    end else begin
      issued_cnt_q <= issued_cnt_d;
      stall_cnt_q  <= stall_cnt_d;
    end
  end

  assign issued_cnt_sched = issued_cnt_q;
  assign stall_cnt_sched  = stall_cnt_q;
`endif

endmodule

// File: tb/tb_rs_issue_sched.sv
// tb_rs_issue_sched: directed testbench for rs_issue_sched (4 entries).
// Exercises reset, in-order fill and drain, age-ordered issue, stall hold,
// illegal allocation, flush and, with RS_ISSUE_STATS_EN, the counters.
module tb_rs_issue_sched;
  import sched_pkg::*;

  logic clk = 1'b0;
  logic res = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  rs_issue_sched_if #(.ENTRIES(RS_ENTRIES)) bus ();

`ifdef RS_ISSUE_STATS_EN
  logic [31:0] issued_cnt, stall_cnt;
`endif

  rs_issue_sched #(.ENTRIES(RS_ENTRIES)) dut (
    .clk (clk),
    .res (res),
    .bus (bus.slave)
`ifdef RS_ISSUE_STATS_EN
    ,
    .issued_cnt_sched(issued_cnt),
    .stall_cnt_sched (stall_cnt)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one edge and settle; outputs are sampled 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic alloc(input entry_idx_t idx);
    bus.alloc_valid_id2sched = 1'b1;
    bus.alloc_idx_id2sched   = idx;
    step();
    bus.alloc_valid_id2sched = 1'b0;
  endtask

  task automatic check_issue(input string tag, input logic v, input entry_idx_t idx);
    check({tag, "_valid"}, 32'(bus.issue_valid_sched2rs), 32'(v));
    check({tag, "_idx"},   32'(bus.issue_idx_sched2rs),   32'(idx));
  endtask

  initial begin
    logic [6:0] opcode;
    opcode = OP_REG;
    bus.alloc_valid_id2sched = 1'b0;
    bus.alloc_idx_id2sched   = '0;
    bus.ready_rs2sched       = '0;
    bus.stop_ex2sched        = 1'b0;
    bus.flush_rob2sched      = 1'b0;

    // Reset state
    step(); step();
    res = 1'b0;
    check_issue("rst_issue", 1'b0, 2'd0);
    check("rst_free", 32'(bus.free_sched2id), 32'hF);
    check("rst_full", 32'(bus.full_sched2id), 32'h0);
    check("rst_err",  32'(bus.alloc_err_sched2id), 32'h0);
    check("op_reg_pkg", 32'(opcode), 32'h33);

    // Fill 0..3 with nothing ready, then drain in index (= age) order
    for (int i = 0; i < 4; i++) alloc(entry_idx_t'(i));
    check("fill_full", 32'(bus.full_sched2id), 32'h1);
    check("fill_free", 32'(bus.free_sched2id), 32'h0);
    check_issue("fill_noissue", 1'b0, 2'd0);
    bus.ready_rs2sched = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      step();
      check_issue($sformatf("drain%0d", i), 1'b1, entry_idx_t'(i));
    end
    step();
    check_issue("drain_done", 1'b0, 2'd0);
    check("drain_free", 32'(bus.free_sched2id), 32'hF);
    bus.ready_rs2sched = '0;
`ifdef RS_ISSUE_STATS_EN
    check("stats_fill_issued", issued_cnt, 32'd4);
    check("stats_fill_stall",  stall_cnt,  32'd0);
`endif

    // Age order 2,0,1 regardless of index
    alloc(2'd2); alloc(2'd0); alloc(2'd1);
    bus.ready_rs2sched = 4'b0111;
    step(); check_issue("age0", 1'b1, 2'd2);
    step(); check_issue("age1", 1'b1, 2'd0);
    step(); check_issue("age2", 1'b1, 2'd1);
    step(); check_issue("age_done", 1'b0, 2'd0);
    bus.ready_rs2sched = '0;

    // Stall: entry 3 held while older entry 1 becomes ready
    alloc(2'd1); alloc(2'd3);
    bus.ready_rs2sched = 4'b1000;
    bus.stop_ex2sched  = 1'b1;
    step(); check_issue("stall_first", 1'b1, 2'd3);
    bus.ready_rs2sched = 4'b1010;
    for (int i = 0; i < 3; i++) begin
      step();
      check_issue($sformatf("stall_hold%0d", i), 1'b1, 2'd3);
    end
    bus.stop_ex2sched = 1'b0;
    step(); check_issue("stall_next", 1'b1, 2'd1);
    step(); check_issue("stall_done", 1'b0, 2'd0);
    check("stall_free", 32'(bus.free_sched2id), 32'hF);
    bus.ready_rs2sched = '0;
`ifdef RS_ISSUE_STATS_EN
    check("stats_mid_issued", issued_cnt, 32'd9);
    check("stats_mid_stall",  stall_cnt,  32'd3);
`endif

    // Illegal allocation into occupied entry 2; error is sticky
    alloc(2'd2);
    check("err_before", 32'(bus.alloc_err_sched2id), 32'h0);
    alloc(2'd2);
    check("err_set",  32'(bus.alloc_err_sched2id), 32'h1);
    check("err_free", 32'(bus.free_sched2id), 32'hB);
    step(); step();
    check("err_sticky", 32'(bus.alloc_err_sched2id), 32'h1);

    // Flush with entry 0 held under stop; same-cycle alloc to 3 dropped
    alloc(2'd0); alloc(2'd1);
    bus.ready_rs2sched = 4'b0011;
    bus.stop_ex2sched  = 1'b1;
    step(); check_issue("fl_issue", 1'b1, 2'd0);
    step(); check_issue("fl_hold",  1'b1, 2'd0);
    bus.flush_rob2sched      = 1'b1;
    bus.alloc_valid_id2sched = 1'b1;
    bus.alloc_idx_id2sched   = 2'd3;
    step();
    bus.flush_rob2sched      = 1'b0;
    bus.alloc_valid_id2sched = 1'b0;
    bus.stop_ex2sched        = 1'b0;
    check_issue("fl_after", 1'b0, 2'd0);
    check("fl_free", 32'(bus.free_sched2id), 32'hF);
    step();
    check_issue("fl_after2", 1'b0, 2'd0);
    check("fl_free2", 32'(bus.free_sched2id), 32'hF);
    check("fl_err_kept", 32'(bus.alloc_err_sched2id), 32'h1);
`ifdef RS_ISSUE_STATS_EN
    check("stats_fl_issued", issued_cnt, 32'd9);
    check("stats_fl_stall",  stall_cnt,  32'd5);
`endif

    // Reset while an issue is held under stop drops it
    bus.ready_rs2sched = '0;
    alloc(2'd0);
    bus.ready_rs2sched = 4'b0001;
    bus.stop_ex2sched  = 1'b1;
    step(); check_issue("rr_held", 1'b1, 2'd0);
    res = 1'b1;
    step();
    res = 1'b0;
    bus.stop_ex2sched  = 1'b0;
    bus.ready_rs2sched = '0;
    check_issue("rr_drop", 1'b0, 2'd0);
    check("rr_free", 32'(bus.free_sched2id), 32'hF);
    check("rr_err",  32'(bus.alloc_err_sched2id), 32'h0);
`ifdef RS_ISSUE_STATS_EN
    check("stats_rst_issued", issued_cnt, 32'd0);
    check("stats_rst_stall",  stall_cnt,  32'd0);
`endif
    step();
    check_issue("rr_idle", 1'b0, 2'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
